// File: rtl/sram_scanout_reader_if.sv
// sram_scanout_reader_if
// Groups the bus-side signals of the scanout reader.
//   Arbiter slot:  read_request, read_address (reader -> arbiter),
//                  read_finished_strobe, read_data (arbiter -> reader)
//   Output stream: out_data, out_valid (reader -> sink), out_ready (sink -> reader)
//
// Handshake semantics:
//   Arbiter slot: read_request is a level held until the completing
//   read_finished_strobe. read_address is stable while read_request is high.
//   read_data is valid only in the cycle read_finished_strobe is high.
//   Output stream: a word transfers on every rising clk edge where
//   out_valid && out_ready. out_data is meaningful only while out_valid is high.
//   out_valid does not depend on out_ready.
//
// master = the reader, slave = the arbiter/sink side.
interface sram_scanout_reader_if #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int DATA_BUS_WIDTH    = 16
);
    logic                         read_request;
    logic [ADDRESS_BUS_WIDTH-1:0] read_address;
    logic                         read_finished_strobe;
    logic [DATA_BUS_WIDTH-1:0]    read_data;
    logic [DATA_BUS_WIDTH-1:0]    out_data;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        output read_request,
        output read_address,
        input  read_finished_strobe,
        input  read_data,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  read_request,
        input  read_address,
        output read_finished_strobe,
        output read_data,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/sram_scanout_reader.sv
// sram_scanout_reader
// Read-side client of the SRAM bus arbiter. On a frame_start pulse it fetches
// word_count consecutive words from base_address, keeping one request
// outstanding at a time. It buffers the words in a small FIFO that drains onto
// a valid/ready stream.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   frame_start   one-cycle pulse that starts a frame (ignored while busy)
//   base_address  first word address, sampled on an accepted frame_start
//   word_count    number of words, sampled on an accepted frame_start
//   busy          frame fetch in progress
//   frame_done    one-cycle pulse after the last word of a frame is buffered
//   state_dbg     current FSM state (0 idle, 1 issue, 2 wait)
//   bus           arbiter slot and output stream (sram_scanout_reader_if.master)
module sram_scanout_reader #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int DATA_BUS_WIDTH    = 16,
    parameter int FIFO_DEPTH        = 4,
    parameter int FIFO_ADDR_BITS    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_start,
    input  logic [ADDRESS_BUS_WIDTH-1:0] base_address,
    input  logic [ADDRESS_BUS_WIDTH-1:0] word_count,
    output logic                         busy,
    output logic                         frame_done,
    output logic [1:0]                   state_dbg,
    sram_scanout_reader_if.master        bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [ADDRESS_BUS_WIDTH-1:0] ADDR_ONE  = ADDRESS_BUS_WIDTH'(1);
    localparam logic [FIFO_ADDR_BITS-1:0]    PTR_ONE   = FIFO_ADDR_BITS'(1);
    localparam logic [FIFO_ADDR_BITS:0]      CNT_ONE   = (FIFO_ADDR_BITS + 1)'(1);
    localparam logic [FIFO_ADDR_BITS:0]      CNT_FULL  = (FIFO_ADDR_BITS + 1)'(FIFO_DEPTH);

    state_t                         state_q, state_d;
    logic [ADDRESS_BUS_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDRESS_BUS_WIDTH-1:0]   remaining_q, remaining_d;
    logic [ADDRESS_BUS_WIDTH-1:0]   read_address_q, read_address_d;
    logic                           read_request_q, read_request_d;
    logic                           busy_q, busy_d;
    logic                           frame_done_q, frame_done_d;

    logic [DATA_BUS_WIDTH-1:0]      mem_q [FIFO_DEPTH];
    logic [DATA_BUS_WIDTH-1:0]      mem_d [FIFO_DEPTH];
    logic [FIFO_ADDR_BITS-1:0]      wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_BITS-1:0]      rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_BITS:0]        count_q, count_d;

    logic fifo_full;
    logic push;
    logic pop;
    logic last_word;

    assign fifo_full = (count_q == CNT_FULL);
    // A strobe outside WAIT (e.g. a completion arriving after a reset) is dropped.
    assign push      = (state_q == ST_WAIT) && bus.read_finished_strobe;
    assign pop       = (count_q != '0) && bus.out_ready;
    assign last_word = (remaining_q == ADDR_ONE);

    // State register plus all datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            remaining_q    <= '0;
            read_address_q <= '0;
            read_request_q <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            remaining_q    <= remaining_d;
            read_address_q <= read_address_d;
            read_request_q <= read_request_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
        // Storage needs no reset; count_q alone decides what is valid.
        mem_q <= mem_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // A zero-length frame completes without ever leaving IDLE.
                if (frame_start && (word_count != '0)) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Issuing only with a free entry means every strobe finds room.
                if (!fifo_full) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.read_finished_strobe) begin
                    state_d = last_word ? ST_IDLE : ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath logic.
    always_comb begin
        addr_d         = addr_q;
        remaining_d    = remaining_q;
        read_address_d = read_address_q;
        read_request_d = read_request_q;
        busy_d         = busy_q;
        frame_done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    addr_d       = base_address;
                    remaining_d  = word_count;
                    busy_d       = (word_count != '0);
                    frame_done_d = (word_count == '0);
                end
            end
            ST_ISSUE: begin
                if (!fifo_full) begin
                    read_request_d = 1'b1;
                    read_address_d = addr_q;
                end
            end
            ST_WAIT: begin
                if (bus.read_finished_strobe) begin
                    // Dropping the request for at least one cycle keeps the
                    // arbiter from re-granting this slot on the stale request.
                    read_request_d = 1'b0;
                    addr_d         = addr_q + ADDR_ONE;
                    remaining_d    = remaining_q - ADDR_ONE;
                    if (last_word) begin
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: begin
                read_request_d = 1'b0;
                busy_d         = 1'b0;
            end
        endcase
    end

    // FIFO bookkeeping; independent of the fetch state.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.read_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    assign bus.read_request = read_request_q;
    assign bus.read_address = read_address_q;
    assign bus.out_data     = mem_q[rd_ptr_q];
    assign bus.out_valid    = (count_q != '0);
    assign busy             = busy_q;
    assign frame_done       = frame_done_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_sram_scanout_reader.sv
module tb_sram_scanout_reader;
    localparam int AW = 16;
    localparam int DW = 16;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic [AW-1:0] base_address = '0;
    logic [AW-1:0] word_count = '0;
    logic          busy;
    logic          frame_done;
    logic [1:0]    state_dbg;

    always #5 clk = ~clk;

    sram_scanout_reader_if #(.ADDRESS_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW)) bus ();

    sram_scanout_reader #(
        .ADDRESS_BUS_WIDTH(AW),
        .DATA_BUS_WIDTH(DW),
        .FIFO_DEPTH(4),
        .FIFO_ADDR_BITS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_start(frame_start),
        .base_address(base_address),
        .word_count(word_count),
        .busy(busy),
        .frame_done(frame_done),
        .state_dbg(state_dbg),
        .bus(bus.master)
    );

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int strobe_cnt = 0;
    int req_rise_cnt = 0;
    int arb_cnt = 0;
    bit arb_en = 1'b1;
    logic prev_req = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Arbiter model (strobe two cycles after request, data = addr ^ 0xA5A5),
    // stream sink and event counters. All sampling on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) done_cnt++;
            if (bus.read_request && !prev_req) req_rise_cnt++;
            prev_req = bus.read_request;

            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check_eq("data_extra", exp_q.size(), 1);
                else check_eq("stream_data", bus.out_data, exp_q.pop_front());
            end

            if (arb_en) begin
                if (bus.read_finished_strobe) begin
                    bus.read_finished_strobe = 1'b0;
                    check_eq("req_gap", bus.read_request, 0);
                end else if (bus.read_request) begin
                    if (arb_cnt == 0) begin
                        if (exp_addr_q.size() == 0) check_eq("addr_extra", exp_addr_q.size(), 1);
                        else check_eq("req_addr", bus.read_address, exp_addr_q.pop_front());
                    end
                    arb_cnt++;
                    if (arb_cnt == 2) begin
                        bus.read_data = bus.read_address ^ 16'hA5A5;
                        bus.read_finished_strobe = 1'b1;
                        strobe_cnt++;
                        arb_cnt = 0;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_frame(input logic [AW-1:0] b, input logic [AW-1:0] n);
        @(posedge clk); #1;
        base_address = b;
        word_count   = n;
        frame_start  = 1'b1;
        @(posedge clk); #1;
        frame_start  = 1'b0;
    endtask

    task automatic wait_drained(input string tag, input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0 && exp_addr_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq(tag, ok, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_request(input string tag, input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.read_request) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq(tag, ok, 1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        bus.read_finished_strobe = 1'b0;
        bus.read_data = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req", bus.read_request, 0);
        check_eq("rst_addr", bus.read_address, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", frame_done, 0);
        check_eq("rst_valid", bus.out_valid, 0);
        check_eq("rst_state", state_dbg, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: basic three-word frame
        done_cnt = 0; strobe_cnt = 0;
        exp_addr_q = '{16'h0100, 16'h0101, 16'h0102};
        exp_q      = '{16'hA4A5, 16'hA4A4, 16'hA4A7};
        start_frame(16'h0100, 16'd3);
        check_eq("t1_busy", busy, 1);
        wait_drained("t1_drain", 100);
        check_eq("t1_done_cnt", done_cnt, 1);
        check_eq("t1_busy_end", busy, 0);
        check_eq("t1_strobes", strobe_cnt, 3);

        // 2: back-pressure, FIFO fills and fetch parks in ISSUE
        bus.out_ready = 1'b0;
        done_cnt = 0; strobe_cnt = 0;
        exp_addr_q = '{16'h0300, 16'h0301, 16'h0302, 16'h0303,
                       16'h0304, 16'h0305, 16'h0306, 16'h0307};
        exp_q      = '{16'hA6A5, 16'hA6A4, 16'hA6A7, 16'hA6A6,
                       16'hA6A1, 16'hA6A0, 16'hA6A3, 16'hA6A2};
        start_frame(16'h0300, 16'd8);
        repeat (30) @(negedge clk);
        check_eq("t2_captured", strobe_cnt, 4);
        check_eq("t2_state_issue", state_dbg, 1);
        check_eq("t2_req_low", bus.read_request, 0);
        check_eq("t2_valid", bus.out_valid, 1);
        check_eq("t2_busy", busy, 1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_drained("t2_drain", 200);
        check_eq("t2_strobes", strobe_cnt, 8);
        check_eq("t2_done_cnt", done_cnt, 1);

        // 3: address wrap
        done_cnt = 0;
        exp_addr_q = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        exp_q      = '{16'h5A5B, 16'h5A5A, 16'hA5A5, 16'hA5A4};
        start_frame(16'hFFFE, 16'd4);
        wait_drained("t3_drain", 100);
        check_eq("t3_done_cnt", done_cnt, 1);

        // 4: zero-length frame
        done_cnt = 0; req_rise_cnt = 0;
        start_frame(16'h0700, 16'd0);
        @(negedge clk);
        check_eq("t4_done_pulse", frame_done, 1);
        check_eq("t4_busy", busy, 0);
        check_eq("t4_state", state_dbg, 0);
        @(negedge clk);
        check_eq("t4_done_clear", frame_done, 0);
        repeat (5) @(negedge clk);
        check_eq("t4_no_req", req_rise_cnt, 0);
        check_eq("t4_done_cnt", done_cnt, 1);

        // 5: frame_start while busy is ignored
        done_cnt = 0; strobe_cnt = 0;
        exp_addr_q = '{16'h1000, 16'h1001, 16'h1002, 16'h1003};
        exp_q      = '{16'hB5A5, 16'hB5A4, 16'hB5A7, 16'hB5A6};
        start_frame(16'h1000, 16'd4);
        wait_request("t5_req_seen", 20);
        @(posedge clk); #1;
        base_address = 16'h2000;
        word_count   = 16'd2;
        frame_start  = 1'b1;
        @(posedge clk); #1;
        frame_start  = 1'b0;
        wait_drained("t5_drain", 100);
        check_eq("t5_strobes", strobe_cnt, 4);
        check_eq("t5_done_cnt", done_cnt, 1);

        // 6: reset while in WAIT, then a late strobe
        arb_en = 1'b0;
        start_frame(16'h4000, 16'd3);
        wait_request("t6_req_seen", 20);
        check_eq("t6_wait_state", state_dbg, 2);
        check_eq("t6_req_addr", bus.read_address, 16'h4000);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("t6_req_dropped", bus.read_request, 0);
        check_eq("t6_valid", bus.out_valid, 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_state", state_dbg, 0);
        bus.read_data = 16'hDEAD;
        bus.read_finished_strobe = 1'b1;
        @(negedge clk);
        bus.read_finished_strobe = 1'b0;
        check_eq("t6_no_write", bus.out_valid, 0);
        @(negedge clk);
        check_eq("t6_no_write_2", bus.out_valid, 0);
        arb_cnt = 0;
        arb_en  = 1'b1;
        done_cnt = 0;
        exp_addr_q = '{16'h5000, 16'h5001};
        exp_q      = '{16'hF5A5, 16'hF5A4};
        start_frame(16'h5000, 16'd2);
        wait_drained("t6_drain", 100);
        check_eq("t6_done_cnt", done_cnt, 1);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_scanout_reader.md
Name: sram_scanout_reader

Overview:
- Read-side client of the SRAM bus arbiter. Occupies one read_requests/read_finished_strobes slot.
- On a frame_start pulse, fetches word_count consecutive 16-bit words starting at base_address, one outstanding request at a time.
- Buffers fetched words in a small FIFO and presents them downstream on a valid/ready stream, for example to an LED panel shifter.

Parameters:
ADDRESS_BUS_WIDTH, 16, SRAM word address width
DATA_BUS_WIDTH, 16, SRAM word width
FIFO_DEPTH, 4, output FIFO entries; must be a power of 2 and at least 2
FIFO_ADDR_BITS, 2, log2(FIFO_DEPTH)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
frame_start  input  1  one-cycle pulse that starts a frame fetch
base_address  input  ADDRESS_BUS_WIDTH  first word address, sampled on an accepted frame_start
word_count  input  ADDRESS_BUS_WIDTH  words to fetch, sampled on an accepted frame_start
read_request  output  1  level request to the arbiter slot
read_address  output  ADDRESS_BUS_WIDTH  address for the arbiter slot; stable while read_request is high
read_finished_strobe  input  1  arbiter completion strobe for this slot
read_data  input  DATA_BUS_WIDTH  shared arbiter data; valid only in the cycle read_finished_strobe is high
out_data  output  DATA_BUS_WIDTH  FIFO head
out_valid  output  1  FIFO not empty
out_ready  input  1  downstream accepts out_data
busy  output  1  frame fetch in progress
frame_done  output  1  one-cycle pulse after the last word of a frame is written into the FIFO

Behaviour:
- Reset values: read_request=0, read_address=0, busy=0, frame_done=0, FIFO emptied (out_valid=0). out_data is don't-care while out_valid=0.
- States: IDLE, ISSUE, WAIT.
- IDLE, frame_start=1:
  - Latch base_address into addr and word_count into remaining; busy<=1.
  - If word_count==0: stay in IDLE, busy stays 0, frame_done pulses the next cycle, no request is issued.
  - Otherwise go to ISSUE.
- frame_start while busy is ignored.
- ISSUE, FIFO not full: read_request<=1, read_address<=addr, go to WAIT.
- ISSUE, FIFO full: hold in ISSUE, no request.
- WAIT, read_finished_strobe=1:
  - Write read_data into the FIFO that same cycle; read_request<=0, so it is low in the following cycle. This prevents the arbiter's IDLE from re-granting the slot.
  - addr<=addr+1, wrapping modulo 2^ADDRESS_BUS_WIDTH; remaining<=remaining-1.
  - If remaining was 1: go to IDLE, busy<=0, frame_done<=1 for one cycle.
  - Else go to ISSUE.
- Minimum spacing between a strobe and the next read_request rising is 1 cycle: the request re-asserts at the edge after ISSUE is entered.
- Credit rule: at most one request is outstanding. A request is issued only when the FIFO has a free entry, so a strobe always finds room.
- A read_finished_strobe while not in WAIT (for example after a reset mid-transfer) is ignored; no FIFO write occurs.
- FIFO:
  - Push on a strobe in WAIT; pop when out_valid && out_ready.
  - Simultaneous push and pop leaves the count unchanged and preserves order.
  - Pointers wrap at FIFO_DEPTH.
  - out_data is the head entry; out_valid = (count != 0).
- Popping is independent of the fetch state. The FIFO may keep draining after frame_done and while idle.
- Reset mid-frame: all state returns to reset values, the FIFO is flushed, and the request is dropped at the next edge.
- Widths: the count register is FIFO_ADDR_BITS+1 bits. remaining and addr are ADDRESS_BUS_WIDTH bits.

Test Plan:
1. base=0x0100, count=3, arbiter model returns data=addr^0xA5A5 two cycles after request, out_ready=1 -> requests at 0x0100, 0x0101, 0x0102. read_request is low for at least 1 cycle after each strobe. Stream is 0xA4A5, 0xA4A4, 0xA4A7. frame_done pulses once, busy then 0.
2. count=8, FIFO_DEPTH=4, out_ready=0 -> exactly 4 words captured, FSM parks in ISSUE, read_request=0. Raising out_ready resumes fetching. All 8 words arrive in order with no loss or duplication.
3. base=0xFFFE, count=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
4. count=0 -> no read_request ever asserted. frame_done pulses the cycle after frame_start. busy stays 0.
5. frame_start pulsed again mid-frame with base=0x2000 -> ignored; the original address sequence continues unchanged.
6. rst asserted while in WAIT, then a late read_finished_strobe arrives -> after reset out_valid=0, read_request=0, and the late strobe causes no FIFO write. A new frame then fetches correctly.
